// File: rtl/sort_loader.sv
// sort_loader
// Upstream feeder for an 8-entry bubble sorter. Accepts world_size-bit words one
// at a time over a valid/ready handshake and packs them into an 8-word parallel
// buffer. After the 8th word is accepted it pulses load for one cycle. It then
// holds off new input for HOLDOFF cycles so the sorter can finish and return to
// its load state.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active-low
//   in_valid            in_data holds a word
//   in_data             input word
//   in_ready            block accepts a word on this cycle's closing edge
//   load                one-cycle start pulse to the sorter
//   busy                high while in LOAD or HOLD
//   data_out0..7        packed batch; word k of the batch is on data_outk
module sort_loader #(
  parameter int world_size = 4,
  parameter int HOLDOFF    = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [world_size-1:0] in_data,
  output logic                  in_ready,
  output logic                  load,
  output logic                  busy,
  output logic [world_size-1:0] data_out0,
  output logic [world_size-1:0] data_out1,
  output logic [world_size-1:0] data_out2,
  output logic [world_size-1:0] data_out3,
  output logic [world_size-1:0] data_out4,
  output logic [world_size-1:0] data_out5,
  output logic [world_size-1:0] data_out6,
  output logic [world_size-1:0] data_out7
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic [7:0]            hcnt_q;
  logic                  in_ready_q;
  logic                  load_q;
  logic                  busy_q;
  logic [world_size-1:0] data_q [8];
  logic                  accept;

  // in_ready_q is only ever high in FILL, so it alone qualifies the handshake.
  assign accept = in_valid && in_ready_q;

  // Outputs are registered: each output register is loaded with the value that
  // belongs to the state being entered, so they change together with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      cnt_q      <= 3'd0;
      hcnt_q     <= 8'd0;
      in_ready_q <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      for (int k = 0; k < 8; k++) data_q[k] <= '0;
    end else begin
      case (state_q)
        FILL: begin
          // Raises in_ready on the first edge after reset release.
          in_ready_q <= 1'b1;
          load_q     <= 1'b0;
          busy_q     <= 1'b0;
          if (accept) begin
            data_q[cnt_q] <= in_data;
            cnt_q         <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_q    <= LOAD;
              in_ready_q <= 1'b0;
              load_q     <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end
        LOAD: begin
          state_q    <= HOLD;
          hcnt_q     <= 8'd0;
          in_ready_q <= 1'b0;
          load_q     <= 1'b0;
          busy_q     <= 1'b1;
        end
        HOLD: begin
          hcnt_q <= hcnt_q + 8'd1;
          if (hcnt_q == HOLD_LAST) begin
            state_q    <= FILL;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          // Unused encoding: restart a clean batch.
          state_q    <= FILL;
          cnt_q      <= 3'd0;
          in_ready_q <= 1'b1;
          load_q     <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign data_out0 = data_q[0];
  assign data_out1 = data_q[1];
  assign data_out2 = data_q[2];
  assign data_out3 = data_q[3];
  assign data_out4 = data_q[4];
  assign data_out5 = data_q[5];
  assign data_out6 = data_q[6];
  assign data_out7 = data_q[7];

endmodule

// File: tb/tb_sort_loader.sv
// tb_sort_loader
// Scoreboard bench for sort_loader: each batch's expected packed contents are
// queued when the words are driven and compared when load pulses. A small sorter
// model captures every loaded batch.
module tb_sort_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready, load, busy;
  logic [3:0] data_out0, data_out1, data_out2, data_out3;
  logic [3:0] data_out4, data_out5, data_out6, data_out7;
  logic [31:0] dout;

  sort_loader #(.world_size(4), .HOLDOFF(40)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load(load), .busy(busy),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
    .data_out3(data_out3), .data_out4(data_out4), .data_out5(data_out5),
    .data_out6(data_out6), .data_out7(data_out7)
  );

  assign dout = {data_out7, data_out6, data_out5, data_out4,
                 data_out3, data_out2, data_out1, data_out0};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [31:0] exp_q[$];
  logic [31:0] sorted_q[$];
  int          load_cyc_q[$];
  logic        prev_load = 1'b0;
  logic [31:0] mon_e;

  // Sorter model: bubble sort of 8 nibbles, element k at bits [4k+:4].
  function automatic logic [31:0] sort_words(input logic [31:0] v);
    logic [3:0] a [8];
    logic [3:0] t;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[4*i +: 4];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = a[i];
    return r;
  endfunction

  // Scoreboard consumer: every load pulse must match the oldest queued batch.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      n_cmp++;
      if (prev_load === 1'b1) begin
        n_err++;
        $display("FAIL load_width: load high 2 cycles at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_load: data_out=%h, no batch pending", dout);
      end else begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        if (dout !== mon_e) begin
          n_err++;
          $display("FAIL load_data: got %h expected %h", dout, mon_e);
        end
      end
      sorted_q.push_back(sort_words(dout));
      load_cyc_q.push_back(cyc);
    end
    prev_load = load;
  end

  task automatic send_word(input logic [3:0] w);
    int  n;
    bit  acc;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    forever begin
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: word %h not accepted, in_ready=%b", w, in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_batch(input logic [31:0] b);
    exp_q.push_back(b);
    for (int k = 0; k < 8; k++) send_word(b[4*k +: 4]);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (load !== 1'b0) begin n_err++; $display("FAIL rst_load: got %b expected 0", load); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h expected 0", dout); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL release_in_ready_pre_edge: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b;
    int n;
    b = 32'h1A290F37;  // words 7,3,F,0,9,2,A,1
    send_batch(b);
    n_cmp++; if (load !== 1'b1) begin n_err++; $display("FAIL b2b_load: got %b expected 1", load); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    n_cmp++; if (dout !== b) begin n_err++; $display("FAIL b2b_data: got %h expected %h", dout, b); end
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      n++;
      if (n == 20) begin
        n_cmp++; if (dout !== b) begin n_err++; $display("FAIL b2b_hold_data: got %h expected %h", dout, b); end
        n_cmp++; if (load !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_hold_ctrl: load=%b busy=%b expected 0 1", load, busy); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (n != 41) begin n_err++; $display("FAIL b2b_ready_low: got %0d cycles expected 41", n); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d batches left expected 0", exp_q.size()); end
  endtask

  task automatic test_gapped();
    logic [31:0] b;
    b = 32'h5C3E81B4;
    exp_q.push_back(b);
    for (int k = 0; k < 8; k++) begin
      send_word(b[4*k +: 4]);
      if (k < 7) begin
        in_data = 4'hF;
        repeat (2) @(posedge clk);
        #1;
      end
      if (k == 6) begin
        n_cmp++; if (load !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL gap_early: load=%b busy=%b expected 0 0", load, busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL gap_ready: got %b expected 1", in_ready); end
      end
    end
    n_cmp++; if (load !== 1'b1) begin n_err++; $display("FAIL gap_load: got %b expected 1", load); end
    wait_ready();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL gap_pending: got %0d batches left expected 0", exp_q.size()); end
  endtask

  task automatic test_hold_input();
    logic [31:0] b;
    b = 32'h87654321;
    send_batch(b);
    in_valid = 1'b1;
    in_data  = 4'h5;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (dout !== b) begin n_err++; $display("FAIL hold_data: got %h expected %h", dout, b); end
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (dout !== 32'h87654325) begin n_err++; $display("FAIL hold_first_word: got %h expected 87654325", dout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int loads;
    logic [31:0] b;
    for (int k = 0; k < 4; k++) send_word(4'(k + 1));
    rst = 1'b0;
    #1;
    n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL mid_rst_data: got %h expected 0", dout); end
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0 || load !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl: ready=%b busy=%b load=%b expected 0 0 0", in_ready, busy, load); end
    @(posedge clk); #1;
    rst = 1'b1;
    loads = load_cyc_q.size();
    repeat (60) @(posedge clk);
    #1;
    n_cmp++; if (load_cyc_q.size() != loads) begin n_err++; $display("FAIL mid_rst_no_load: got %0d loads expected %0d", load_cyc_q.size(), loads); end
    b = 32'h2468ACE1;
    send_batch(b);
    wait_ready();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_rst_pending: got %0d expected 0", exp_q.size()); end
    n_cmp++; if (dout !== b) begin n_err++; $display("FAIL mid_rst_fresh: got %h expected %h", dout, b); end
  endtask

  task automatic test_two_batches();
    logic [31:0] s;
    load_cyc_q.delete();
    sorted_q.delete();
    send_batch(32'h8D06B2E4);  // 4,E,2,B,6,0,D,8
    send_batch(32'hA57C1F33);  // 3,3,F,1,C,7,5,A
    wait_ready();
    n_cmp++;
    if (load_cyc_q.size() != 2 || sorted_q.size() != 2) begin
      n_err++;
      $display("FAIL two_load_count: got %0d loads expected 2", load_cyc_q.size());
    end else begin
      n_cmp++; if (load_cyc_q[1] - load_cyc_q[0] < 37) begin n_err++; $display("FAIL two_spacing: got %0d cycles expected >= 37", load_cyc_q[1] - load_cyc_q[0]); end
      n_cmp++; if (sorted_q[0] !== 32'hEDB86420) begin n_err++; $display("FAIL two_sorted_a: got %h expected edb86420", sorted_q[0]); end
      n_cmp++; if (sorted_q[1] !== 32'hFCA75331) begin n_err++; $display("FAIL two_sorted_b: got %h expected fca75331", sorted_q[1]); end
      for (int m = 0; m < 2; m++) begin
        s = sorted_q[m];
        for (int i = 0; i < 7; i++) begin
          n_cmp++;
          if (s[4*i +: 4] > s[4*(i+1) +: 4]) begin n_err++; $display("FAIL two_ascending: batch %0d pos %0d got %h > %h", m, i, s[4*i +: 4], s[4*(i+1) +: 4]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_hold_input();
    test_reset_mid();
    test_two_batches();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
